// File: rtl/riscv_mc_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, datapath mux codes,
// ALU operations, opcodes and the packed control bundle driven each cycle.
package riscv_mc_controller_pkg;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMREAD   = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWRITE  = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_JALR_LINK = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
  localparam logic [3:0] S_AUIPC     = 4'd14;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h1;
  localparam logic [3:0] ALU_AND   = 4'h2;
  localparam logic [3:0] ALU_OR    = 4'h3;
  localparam logic [3:0] ALU_XOR   = 4'h4;
  localparam logic [3:0] ALU_SLT   = 4'h5;
  localparam logic [3:0] ALU_SLTU  = 4'h6;
  localparam logic [3:0] ALU_SLL   = 4'h7;
  localparam logic [3:0] ALU_SRL   = 4'h8;
  localparam logic [3:0] ALU_SRA   = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       retire;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
  } ctrl_t;

  // beq/bge/bgeu branch when the compare result is zero; bne/blt/bltu when it is not.
  function automatic logic br_take_on_zero(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3[2] && f3[0]);
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// funct3/funct7b5 to ALUControl for R-type and I-type ALU instructions.
module riscv_alu_decoder
  import riscv_mc_controller_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_imm,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      3'b000: alu_control = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      // srai keeps its funct7b5 in the immediate, so it is honoured for I-type too
      3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM: sequences a shared-ALU, single-memory-port datapath,
// stalls on the MemReq/MemReady handshake and traps on illegal ops or bus timeout.
module riscv_mc_controller
  import riscv_mc_controller_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Retire,
  output logic       Illegal,
  output logic       BusTimeout
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  logic [3:0]    state, state_n, dec_next;
  logic [CW-1:0] wait_cnt;
  logic          illegal_q, timeout_q;
  logic          timeout_hit;
  logic [3:0]    alu_dec;
  ctrl_t         c;

  riscv_alu_decoder u_alu_dec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_imm      (state == S_EXEC_I),
    .alu_control (alu_dec)
  );

  always_comb begin
    dec_next = S_TRAP;
    case (Op)
      OP_LOAD, OP_STORE: dec_next = S_MEMADR;
      OP_R:              dec_next = S_EXEC_R;
      OP_I:              dec_next = S_EXEC_I;
      OP_BRANCH:         dec_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
      OP_JAL:            dec_next = S_JAL;
      OP_JALR:           dec_next = S_JALR;
      OP_LUI:            dec_next = S_LUI;
      OP_AUIPC:          dec_next = S_AUIPC;
      default:           dec_next = S_TRAP;
    endcase
  end

  always_comb begin
    c       = '0;
    state_n = state;
    case (state)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b0;
        if (MemReady) begin
          c.ir_write   = 1'b1;
          c.pc_write   = 1'b1;
          c.alu_src_a  = SRCA_PC;
          c.alu_src_b  = SRCB_FOUR;
          c.result_src = RES_ALURES;
          state_n      = S_DECODE;
        end
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = (Op == OP_JAL) ? IMM_J : IMM_B;
        state_n     = dec_next;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_RD1;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = (Op == OP_STORE) ? IMM_S : IMM_I;
        state_n     = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
        if (MemReady) state_n = S_MEMWB;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
        state_n      = S_FETCH;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
        if (MemReady) begin
          c.retire = 1'b1;
          state_n  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        c.alu_src_a   = SRCA_RD1;
        c.alu_src_b   = SRCB_RD2;
        c.alu_control = alu_dec;
        state_n       = S_ALUWB;
      end
      S_EXEC_I: begin
        c.alu_src_a   = SRCA_RD1;
        c.alu_src_b   = SRCB_IMM;
        c.imm_src     = IMM_I;
        c.alu_control = alu_dec;
        state_n       = S_ALUWB;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
        c.retire     = 1'b1;
        state_n      = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE
        c.alu_src_a   = SRCA_RD1;
        c.alu_src_b   = SRCB_RD2;
        c.result_src  = RES_ALUOUT;
        c.alu_control = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        c.pc_write    = br_take_on_zero(funct3) ? Zero : !Zero;
        c.retire      = 1'b1;
        state_n       = S_FETCH;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.result_src = RES_ALUOUT;
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        state_n      = S_ALUWB;
      end
      S_JALR: begin
        c.alu_src_a  = SRCA_RD1;
        c.alu_src_b  = SRCB_IMM;
        c.imm_src    = IMM_I;
        c.result_src = RES_ALURES;
        c.pc_write   = 1'b1;
        state_n      = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_FOUR;
        state_n     = S_ALUWB;
      end
      S_LUI: begin
        c.alu_src_b   = SRCB_IMM;
        c.imm_src     = IMM_U;
        c.alu_control = ALU_PASSB;
        state_n       = S_ALUWB;
      end
      S_AUIPC: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.imm_src   = IMM_U;
        state_n     = S_ALUWB;
      end
      default: state_n = S_TRAP;
    endcase
    if (timeout_hit) state_n = S_TRAP;
  end

  // A MemReady on the final allowed wait cycle still completes the request
  assign timeout_hit = (BUS_TIMEOUT != 0) && c.mem_req && !MemReady &&
                       (wait_cnt == CW'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE && dec_next == S_TRAP) illegal_q <= 1'b1;
      if (timeout_hit) timeout_q <= 1'b1;
      if ((BUS_TIMEOUT != 0) && c.mem_req && !MemReady && !timeout_hit)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  assign MemReq     = c.mem_req   & ~reset;
  assign MemWrite   = c.mem_write & ~reset;
  assign IRWrite    = c.ir_write  & ~reset;
  assign PCWrite    = c.pc_write  & ~reset;
  assign RegWrite   = c.reg_write & ~reset;
  assign Retire     = c.retire    & ~reset;
  assign AdrSrc     = c.adr_src;
  assign ResultSrc  = c.result_src;
  assign ALUSrcA    = c.alu_src_a;
  assign ALUSrcB    = c.alu_src_b;
  assign ImmSrc     = c.imm_src;
  assign ALUControl = c.alu_control;
  assign Illegal    = illegal_q;
  assign BusTimeout = timeout_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench: each driven cycle queues a hand-written expected control word
// (with don't-care mask); a negedge monitor pops and compares against the DUT outputs.
module tb_riscv_mc_controller;

  localparam int D = -1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Retire, Illegal, BusTimeout;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  logic [6:0] op_n = '0;
  logic [2:0] f3_n = '0;
  logic       f7_n = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [21:0] val;
    logic [21:0] mask;
  } exp_t;

  exp_t q[$];

  riscv_mc_controller #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Retire(Retire), .Illegal(Illegal), .BusTimeout(BusTimeout)
  );

  always #5 clk = ~clk;

  // stb = {MemReq,MemWrite,IRWrite,PCWrite,RegWrite,Retire}; flg = {Illegal,BusTimeout}; -1 = don't care
  function automatic void push(string nm, logic [5:0] stb, int flg, int adr, int rs,
                               int a, int b, int imm, int alu);
    exp_t e;
    e.nm = nm; e.val = '0; e.mask = '0;
    e.val[21:16] = stb; e.mask[21:16] = '1;
    if (flg >= 0) begin e.val[15:14] = 2'(flg); e.mask[15:14] = '1; end
    if (adr >= 0) begin e.val[13]    = 1'(adr); e.mask[13]    = 1'b1; end
    if (rs  >= 0) begin e.val[12:11] = 2'(rs);  e.mask[12:11] = '1; end
    if (a   >= 0) begin e.val[10:9]  = 2'(a);   e.mask[10:9]  = '1; end
    if (b   >= 0) begin e.val[8:7]   = 2'(b);   e.mask[8:7]   = '1; end
    if (imm >= 0) begin e.val[6:4]   = 3'(imm); e.mask[6:4]   = '1; end
    if (alu >= 0) begin e.val[3:0]   = 4'(alu); e.mask[3:0]   = '1; end
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [21:0] obs;
      e = q.pop_front();
      obs = {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, Retire, Illegal, BusTimeout,
             AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
      checks++;
      if (((obs ^ e.val) & e.mask) != '0) begin
        errors++;
        $display("FAIL %s @%0t: got %06h want %06h (mask %06h)", e.nm, $time, obs, e.val, e.mask);
      end
    end
  end

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_n = op; f3_n = f3; f7_n = f7;
  endtask

  task automatic cyc(input logic rst, input logic z, input logic rdy, input string nm,
                     input logic [5:0] stb, input int flg, input int adr, input int rs,
                     input int a, input int b, input int imm, input int alu);
    @(posedge clk);
    #1;
    reset = rst; Zero = z; MemReady = rdy;
    Op = op_n; funct3 = f3_n; funct7b5 = f7_n;
    push(nm, stb, flg, adr, rs, a, b, imm, alu);
  endtask

  task automatic fetch();
    cyc(0, 0, 1, "fetch", 6'b101100, 0, 0, 2, 0, 2, D, 0);
  endtask

  task automatic dec(input int imm);
    cyc(0, 0, 0, "decode", 6'b000000, 0, D, D, 1, 1, imm, 0);
  endtask

  task automatic alu_wb();
    cyc(0, 0, 0, "aluwb", 6'b000011, 0, D, 0, D, D, D, D);
  endtask

  task automatic rst_cyc();
    cyc(1, 0, 1, "reset", 6'b000000, D, D, D, D, D, D, D);
  endtask

  task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7, input int alu);
    instr(op, f3, f7);
    fetch();
    dec(2);
    if (op == 7'b0010011) cyc(0, 0, 0, "exec_i", 6'b000000, 0, D, D, 2, 1, 0, alu);
    else                  cyc(0, 0, 0, "exec_r", 6'b000000, 0, D, D, 2, 0, D, alu);
    alu_wb();
  endtask

  task automatic run_br(input logic [2:0] f3, input logic z, input logic take, input int alu);
    instr(7'b1100011, f3, 0);
    fetch();
    dec(2);
    cyc(0, z, 0, "branch", take ? 6'b000101 : 6'b000001, 0, D, 0, 2, 0, D, alu);
  endtask

  initial begin
    rst_cyc();
    rst_cyc();

    // add x3,x1,x2 after a two-cycle fetch stall
    instr(7'b0110011, 3'b000, 0);
    cyc(0, 0, 0, "fetch_wait", 6'b100000, 0, 0, D, D, D, D, D);
    cyc(0, 0, 0, "fetch_wait", 6'b100000, 0, 0, D, D, D, D, D);
    fetch();
    dec(2);
    cyc(0, 0, 0, "exec_r_add", 6'b000000, 0, D, D, 2, 0, D, 0);
    alu_wb();

    run_alu(7'b0110011, 3'b000, 1, 1);  // sub
    run_alu(7'b0110011, 3'b111, 0, 2);  // and
    run_alu(7'b0110011, 3'b101, 1, 9);  // sra
    run_alu(7'b0110011, 3'b001, 0, 7);  // sll
    run_alu(7'b0010011, 3'b000, 1, 0);  // addi ignores funct7b5
    run_alu(7'b0010011, 3'b101, 1, 9);  // srai
    run_alu(7'b0010011, 3'b101, 0, 8);  // srli
    run_alu(7'b0010011, 3'b011, 0, 6);  // sltiu

    run_br(3'b000, 1, 1, 1);  // beq taken
    run_br(3'b001, 1, 0, 1);  // bne not taken
    run_br(3'b100, 0, 1, 5);  // blt taken
    run_br(3'b101, 0, 0, 5);  // bge not taken
    run_br(3'b111, 1, 1, 6);  // bgeu taken
    run_br(3'b110, 1, 0, 6);  // bltu not taken

    // lw: MemReady low 3 cycles, arrives on the 4th wait cycle (timeout boundary, no trap)
    instr(7'b0000011, 3'b010, 0);
    fetch();
    dec(2);
    cyc(0, 0, 1, "memadr_ld", 6'b000000, 0, D, D, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, "memread_wait", 6'b100000, 0, 1, D, D, D, D, D);
    cyc(0, 0, 1, "memread", 6'b100000, 0, 1, D, D, D, D, D);
    cyc(0, 0, 0, "memwb", 6'b000011, 0, D, 1, D, D, D, D);

    // sw, no stall
    instr(7'b0100011, 3'b010, 0);
    fetch();
    dec(2);
    cyc(0, 0, 0, "memadr_st", 6'b000000, 0, D, D, 2, 1, 1, 0);
    cyc(0, 0, 1, "memwrite", 6'b110001, 0, 1, D, D, D, D, D);

    instr(7'b1101111, 3'b000, 0);
    fetch();
    dec(3);
    cyc(0, 0, 0, "jal", 6'b000100, 0, D, 0, 1, 2, D, 0);
    alu_wb();

    instr(7'b1100111, 3'b000, 0);
    fetch();
    dec(2);
    cyc(0, 0, 0, "jalr", 6'b000100, 0, D, 2, 2, 1, 0, 0);
    cyc(0, 0, 0, "jalr_link", 6'b000000, 0, D, D, 1, 2, D, 0);
    alu_wb();

    instr(7'b0110111, 3'b000, 0);
    fetch();
    dec(2);
    cyc(0, 0, 0, "lui", 6'b000000, 0, D, D, D, 1, 4, 10);
    alu_wb();

    instr(7'b0010111, 3'b000, 0);
    fetch();
    dec(2);
    cyc(0, 0, 0, "auipc", 6'b000000, 0, D, D, 1, 1, 4, 0);
    alu_wb();

    // reset mid-MEMWRITE: strobes drop, no Retire, then a clean store
    instr(7'b0100011, 3'b010, 0);
    fetch();
    dec(2);
    cyc(0, 0, 0, "memadr_st", 6'b000000, 0, D, D, 2, 1, 1, 0);
    cyc(0, 0, 0, "memwrite_wait", 6'b110000, 0, 1, D, D, D, D, D);
    cyc(1, 0, 1, "reset_in_memwrite", 6'b000000, 0, D, D, D, D, D, D);
    fetch();
    dec(2);
    cyc(0, 0, 0, "memadr_st", 6'b000000, 0, D, D, 2, 1, 1, 0);
    cyc(0, 0, 1, "memwrite", 6'b110001, 0, 1, D, D, D, D, D);

    // bus timeout: 4 wait cycles with no MemReady
    fetch();
    dec(2);
    cyc(0, 0, 0, "memadr_st", 6'b000000, 0, D, D, 2, 1, 1, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 0, "memwrite_wait", 6'b110000, 0, 1, D, D, D, D, D);
    cyc(0, 0, 1, "trap_timeout", 6'b000000, 1, D, D, D, D, D, D);
    cyc(0, 0, 1, "trap_timeout_hold", 6'b000000, 1, D, D, D, D, D, D);
    rst_cyc();

    // illegal opcode; the following fetch checks the sticky flags cleared
    instr(7'b0000000, 3'b000, 0);
    fetch();
    dec(2);
    cyc(0, 0, 1, "trap_illegal", 6'b000000, 2, D, D, D, D, D, D);
    cyc(0, 0, 1, "trap_illegal_hold", 6'b000000, 2, D, D, D, D, D, D);
    rst_cyc();

    // branch with funct3=010 is illegal
    instr(7'b1100011, 3'b010, 0);
    fetch();
    dec(2);
    cyc(0, 1, 1, "trap_bad_branch", 6'b000000, 2, D, D, D, D, D, D);
    rst_cyc();
    fetch();

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
